sqm_sample_decimator: RTL and testbench

- Downstream consumer of the two SQM_AMP mixer outputs on the 1942 sound board.
- Sums both amplifier words every clock and low-pass filters the sum with a 2^TAPS_LOG2-tap moving average.
- Decimates to the audio sample rate with a fractional phase accumulator.
- Presents 16-bit samples on a valid/ready handshake to a sample sink (file writer, DAC serializer).

---
 rtl/sqm_sample_decimator_if.sv | 34 +++
 rtl/sqm_sample_decimator.sv | 135 +++++++++++++
 tb/tb_sqm_sample_decimator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sqm_sample_decimator_if.sv
// rtl/sqm_sample_decimator_if.sv - mixer input, sample stream and status bundle for the decimator
//
// Purpose: groups the amplifier inputs, the valid/ready sample stream and the
// overrun status/clear pair into one bundle.
// Ports (signals):
//   amp0_y, amp1_y  [15:0]  unsigned amplifier words      (into decimator)
//   sample_out      [15:0]  filtered, decimated sample     (out of decimator)
//   sample_valid            sample_out holds an unconsumed sample
//   sample_ready            sink accepts sample_out together with sample_valid
//   tick                    one-cycle pulse at every decimation instant
//   overrun                 sticky: a tick arrived while a sample was pending
//   overrun_clr             synchronous clear of overrun
// master = decimator side, slave = sink/driver side.

interface sqm_sample_decimator_if;
    logic [15:0] amp0_y;
    logic [15:0] amp1_y;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        tick;
    logic        overrun;
    logic        overrun_clr;

    modport master (
        input  amp0_y, amp1_y, sample_ready, overrun_clr,
        output sample_out, sample_valid, tick, overrun
    );

    modport slave (
        output amp0_y, amp1_y, sample_ready, overrun_clr,
        input  sample_out, sample_valid, tick, overrun
    );
endinterface

// File: rtl/sqm_sample_decimator.sv
// rtl/sqm_sample_decimator.sv - sums two amplifier words, moving-average filters and decimates to audio rate
//
// Purpose: every clock the two amplifier words are summed and pushed through a
// 2^TAPS_LOG2-tap moving average. A fractional phase accumulator picks out
// SAMPLE_HZ decimation instants per CLK_HZ clocks; at each one the averaged,
// halved sum is offered on a valid/ready handshake.
// Ports:
//   clk    input   rising-edge clock
//   reset  input   asynchronous, active-high reset
//   bus    master  amp0_y/amp1_y in, sample_out/sample_valid/sample_ready stream,
//                  tick debug pulse, overrun sticky flag with overrun_clr

module sqm_sample_decimator #(
    parameter int unsigned CLK_HZ    = 2994012,
    parameter int unsigned SAMPLE_HZ = 44100,
    parameter int unsigned TAPS_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    sqm_sample_decimator_if.master  bus
);

    localparam int unsigned DEPTH = 1 << TAPS_LOG2;
    localparam int          SUM_W = 17 + TAPS_LOG2;
    localparam logic [32:0] P_CLK = 33'(CLK_HZ);
    localparam logic [32:0] P_SMP = 33'(SAMPLE_HZ);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    logic [16:0]          r_buf [DEPTH];
    logic [SUM_W-1:0]     r_sum;
    logic [TAPS_LOG2-1:0] r_wptr;
    logic [31:0]          r_phase;
    logic [15:0]          r_sample;
    logic                 r_overrun;
    state_t               r_state;

    logic [16:0]          w_in;
    logic [SUM_W-1:0]     w_sum_nxt;
    logic [15:0]          w_filt;
    logic [32:0]          w_phase_sum;
    logic [31:0]          w_phase_nxt;
    logic                 w_tick;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_ovr_evt;

    // Mixer: 17-bit sum cannot overflow; the window sum is wide enough for
    // 2^TAPS_LOG2 full-scale entries.
    assign w_in      = {1'b0, bus.amp0_y} + {1'b0, bus.amp1_y};
    assign w_sum_nxt = r_sum + SUM_W'(w_in) - SUM_W'(r_buf[r_wptr]);

    // Average over the window and halve the two-amplifier sum in one shift.
    // The top 16 bits of the window sum are exactly that quotient.
    assign w_filt = w_sum_nxt[SUM_W-1 -: 16];

    // Phase accumulator: a tick whenever the accumulated SAMPLE_HZ crosses CLK_HZ.
    assign w_phase_sum = {1'b0, r_phase} + P_SMP;
    assign w_tick      = (w_phase_sum >= P_CLK);
    assign w_phase_nxt = w_tick ? 32'(w_phase_sum - P_CLK) : w_phase_sum[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_sum   <= '0;
            r_wptr  <= '0;
            r_phase <= '0;
        end else begin
            r_buf[r_wptr] <= w_in;
            r_sum         <= w_sum_nxt;
            r_wptr        <= r_wptr + TAPS_LOG2'(1);
            r_phase       <= w_phase_nxt;
        end
    end

    // Output handshake state: S_FULL means sample_out holds an unconsumed sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_EMPTY;
            r_sample  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_sample <= w_filt;
            end
            // A new overrun event beats a simultaneous clear.
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovr_evt   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_tick) begin
                    // Consumed this cycle: replace; otherwise drop the new one.
                    if (bus.sample_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_ovr_evt = 1'b1;
                    end
                end else if (bus.sample_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    assign bus.sample_out   = r_sample;
    assign bus.sample_valid = (r_state == S_FULL);
    assign bus.tick         = w_tick;
    assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_sqm_sample_decimator.sv
// tb/tb_sqm_sample_decimator.sv - randomized self-checking bench for sqm_sample_decimator

module tb_sqm_sample_decimator;

    localparam longint C_HZ = 2994012;
    localparam longint S_HZ = 44100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sqm_sample_decimator_if bus ();
    sqm_sample_decimator_if bus2 ();

    sqm_sample_decimator dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    sqm_sample_decimator #(
        .CLK_HZ    (10),
        .SAMPLE_HZ (3),
        .TAPS_LOG2 (6)
    ) dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2.master)
    );

    always #5 clk = ~clk;

    int     n_cmp  = 0;
    int     n_fail = 0;
    bit     chk_en = 1'b0;
    int     mode   = 0;

    int     hist[$];
    longint m_n;
    bit     m_valid;
    bit     m_ovr;
    bit     m_tick;
    int     m_out;

    int     cur_a0, cur_a1;
    bit     cur_rdy, cur_clr, cur_rst;

    int     tick10[6] = '{4, 7, 10, 14, 17, 20};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tick in cycle n (n >= 1 after reset release) iff floor(n*S/C) advances.
    function automatic bit tick_at(input longint n);
        return ((n * S_HZ) / C_HZ) != (((n - 1) * S_HZ) / C_HZ);
    endfunction

    // Mean of the last 64 mixer sums (this cycle included), halved.
    function automatic int filt_of(input int x);
        int sum;
        int start;
        sum   = x;
        start = (hist.size() == 64) ? 1 : 0;
        for (int i = start; i < hist.size(); i++) sum += hist[i];
        return (sum / 128) & 16'hFFFF;
    endfunction

    task automatic model_clear();
        hist.delete();
        m_n     = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_out   = 0;
        m_tick  = 1'b0;
    endtask

    // Advance the model across the edge that ends the current cycle.
    task automatic step_model();
        int x;
        int f;
        bit evt;
        if (cur_rst) begin
            model_clear();
        end else begin
            x   = cur_a0 + cur_a1;
            f   = filt_of(x);
            evt = m_tick && m_valid && !cur_rdy;
            if (m_tick && (!m_valid || cur_rdy)) begin
                m_out   = f;
                m_valid = 1'b1;
            end else if (!m_tick && m_valid && cur_rdy) begin
                m_valid = 1'b0;
            end
            if (evt) m_ovr = 1'b1;
            else if (cur_clr) m_ovr = 1'b0;
            hist.push_back(x);
            if (hist.size() > 64) void'(hist.pop_front());
            m_n++;
        end
    endtask

    task automatic apply(input int a0, input int a1, input bit rdy, input bit clr, input bit r);
        cur_a0  = a0;
        cur_a1  = a1;
        cur_rdy = rdy;
        cur_clr = clr;
        cur_rst = r;
        bus.amp0_y       = a0[15:0];
        bus.amp1_y       = a1[15:0];
        bus.sample_ready = rdy;
        bus.overrun_clr  = clr;
        rst              = r;
        if (r) model_clear();
        m_tick = r ? 1'b0 : tick_at(m_n + 1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        step_model();
    endtask

    task automatic run(input int md, input int a0, input int a1, input bit rdy, input bit clr, input bit r);
        next_cycle();
        mode = md;
        apply(a0, a1, rdy, clr, r);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("sample_valid", bus.sample_valid, m_valid);
            check("sample_out", bus.sample_out, m_out);
            check("overrun", bus.overrun, m_ovr);
            check("tick", bus.tick, m_tick);
            if (mode == 1 && !rst && m_n + 1 <= 20) begin
                bit exp_t;
                exp_t = 1'b0;
                foreach (tick10[i]) if (longint'(tick10[i]) == m_n + 1) exp_t = 1'b1;
                check("tick_10_3", bus2.tick, exp_t);
            end
            case (mode)
                1: if (bus.sample_valid) check("settled_2000", bus.sample_out, 2000);
                2: if (bus.sample_valid) check("full_scale", bus.sample_out, 65535);
                6: if (bus.sample_valid) check("const_4000", bus.sample_out, 2000);
                7: begin
                    if (rst) begin
                        check("rst_sample_out", bus.sample_out, 0);
                        check("rst_valid", bus.sample_valid, 0);
                        check("rst_overrun", bus.overrun, 0);
                    end else if (bus.sample_valid) begin
                        check("post_reset_zero", bus.sample_out, 0);
                    end
                end
                default: ;
            endcase
        end
    end

    initial begin
        bit found;
        bus2.amp0_y       = 16'd0;
        bus2.amp1_y       = 16'd0;
        bus2.sample_ready = 1'b1;
        bus2.overrun_clr  = 1'b0;
        model_clear();

        // Constant 1000+3000 from reset, sink always ready.
        mode = 1;
        apply(1000, 3000, 1, 0, 1);
        chk_en = 1'b1;
        run(1, 1000, 3000, 1, 0, 1);
        repeat (300) run(1, 1000, 3000, 1, 0, 0);

        // Full scale on both amplifiers.
        run(2, 65535, 65535, 1, 0, 1);
        repeat (300) run(2, 65535, 65535, 1, 0, 0);

        // Random inputs, random backpressure, occasional clear and reset.
        run(3, 0, 0, 1, 0, 1);
        repeat (8000) begin
            run(3, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 2500) == 0);
        end

        // Backpressure across two ticks, then clear, then clear colliding with a new overrun.
        run(4, 0, 0, 1, 0, 1);
        repeat (140) run(4, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0, 0, 0);
        run(4, 500, 500, 0, 1, 0);
        check("ovr_after_two_ticks", bus.overrun, 1);
        check("valid_held", bus.sample_valid, 1);
        run(4, 500, 500, 0, 0, 0);
        check("ovr_cleared", bus.overrun, 0);
        check("valid_after_clr", bus.sample_valid, 1);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            bit t;
            next_cycle();
            t = tick_at(m_n + 1);
            apply(700, 700, 0, t, 0);
            if (t) begin
                found = 1'b1;
                break;
            end
        end
        check("simul_tick_found", found, 1);
        next_cycle();
        check("ovr_set_wins", bus.overrun, 1);
        apply(700, 700, 1, 0, 0);
        repeat (100) run(4, 700, 700, 1, 0, 0);

        // Settle on 4000, reset mid-operation, then silence.
        run(6, 2000, 2000, 1, 0, 1);
        repeat (200) run(6, 2000, 2000, 1, 0, 0);
        run(7, 0, 0, 1, 0, 1);
        repeat (300) run(7, 0, 0, 1, 0, 0);

        @(posedge clk);
        chk_en = 1'b0;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
